// File: rtl/alu_issue_pkg.sv
// Shared types and ALU function codes for the operand-issue stage.
// Optional build macro RF_ZERO_REG_EN (consumed by alu_regfile) hardwires register 0 to zero.
package alu_issue_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_ANDN = 3'b100;
    localparam logic [2:0] F_ORN  = 3'b101;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_SLT  = 3'b111;

endpackage

// File: rtl/alu_regfile.sv
// NREGS x DATA_W register array: one write port, two operand read ports and a debug read port.
// Build macro RF_ZERO_REG_EN: register 0 reads as zero and ignores writes.
module alu_regfile
    import alu_issue_pkg::*;
#(
    parameter int unsigned  DATA_W = 4,
    parameter int unsigned  NREGS  = 8,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic [ADDR_W-1:0] raddr_dbg,
    output logic [DATA_W-1:0] rdata_dbg
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    always_comb begin
        regs_d = regs_q;
        if (we) begin
            regs_d[waddr] = wdata;
        end
`ifdef RF_ZERO_REG_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

`ifdef RF_ZERO_REG_EN
    assign rdata_a   = (raddr_a   == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b   = (raddr_b   == '0) ? '0 : regs_q[raddr_b];
    assign rdata_dbg = (raddr_dbg == '0) ? '0 : regs_q[raddr_dbg];
`else
    assign rdata_a   = regs_q[raddr_a];
    assign rdata_b   = regs_q[raddr_b];
    assign rdata_dbg = regs_q[raddr_dbg];
`endif

endmodule

// File: rtl/alu_issue_rf.sv
// Operand-issue stage for the external 4-bit ALU: accepts a micro-op, registers its operands,
// then writes the ALU result back and latches the zero flag. RF_ZERO_REG_EN applies via alu_regfile.
module alu_issue_rf
    import alu_issue_pkg::*;
#(
    parameter int unsigned  DATA_W = 4,
    parameter int unsigned  NREGS  = 8,
    localparam int unsigned ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [2:0]        op_funcsel,
    input  logic [ADDR_W-1:0] op_rd,
    input  logic [ADDR_W-1:0] op_rs1,
    input  logic [ADDR_W-1:0] op_rs2,
    input  logic              op_imm_en,
    input  logic [DATA_W-1:0] op_imm,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [2:0]        alu_funcsel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              done,
    output logic              zero_flag,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic [2:0]        funcsel_q, funcsel_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic              zero_flag_q, zero_flag_d;
    logic              wb_en;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (wb_en),
        .waddr     (rd_q),
        .wdata     (alu_result),
        .raddr_a   (op_rs1),
        .rdata_a   (rs1_data),
        .raddr_b   (op_rs2),
        .rdata_b   (rs2_data),
        .raddr_dbg (dbg_addr),
        .rdata_dbg (dbg_data)
    );

    always_comb begin
        state_d     = state_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        funcsel_d   = funcsel_q;
        rd_d        = rd_q;
        zero_flag_d = zero_flag_q;
        op_ready    = 1'b0;
        done        = 1'b0;
        wb_en       = 1'b0;
        unique case (state_q)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    op_a_d    = rs1_data;
                    op_b_d    = op_imm_en ? op_imm : rs2_data;
                    funcsel_d = op_funcsel;
                    rd_d      = op_rd;
                    state_d   = EXEC;
                end
            end
            // Operands have been stable for a full cycle, so the ALU output is settled here.
            EXEC: begin
                wb_en       = 1'b1;
                zero_flag_d = alu_zero;
                state_d     = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            funcsel_q   <= '0;
            rd_q        <= '0;
            zero_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            funcsel_q   <= funcsel_d;
            rd_q        <= rd_d;
            zero_flag_q <= zero_flag_d;
        end
    end

    assign alu_operand_a = op_a_q;
    assign alu_operand_b = op_b_q;
    assign alu_funcsel   = funcsel_q;
    assign zero_flag     = zero_flag_q;

endmodule

// File: tb/tb_alu_issue_rf.sv
// Bench for alu_issue_rf with a behavioural 4-bit ALU beside it and a write-back scoreboard.
// Build macro RF_ZERO_REG_EN is honoured by the register model.
module tb_alu_issue_rf;
    import alu_issue_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_funcsel;
    logic [2:0] op_rd, op_rs1, op_rs2;
    logic       op_imm_en;
    logic [3:0] op_imm;
    logic [3:0] alu_operand_a, alu_operand_b;
    logic [2:0] alu_funcsel;
    logic [3:0] alu_result;
    logic       alu_zero;
    logic       done;
    logic       zero_flag;
    logic [2:0] dbg_addr, main_addr, mon_addr;
    logic       mon_active = 1'b0;
    logic [3:0] dbg_data;

    typedef struct {
        logic [2:0] rd;
        logic [3:0] val;
        logic       zero;
        int         done_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] mregs [8];
    int         cyc = 0;
    int         done_cnt = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dbg_addr = mon_active ? mon_addr : main_addr;

    alu_issue_rf dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_funcsel    (op_funcsel),
        .op_rd         (op_rd),
        .op_rs1        (op_rs1),
        .op_rs2        (op_rs2),
        .op_imm_en     (op_imm_en),
        .op_imm        (op_imm),
        .alu_operand_a (alu_operand_a),
        .alu_operand_b (alu_operand_b),
        .alu_funcsel   (alu_funcsel),
        .alu_result    (alu_result),
        .alu_zero      (alu_zero),
        .done          (done),
        .zero_flag     (zero_flag),
        .dbg_addr      (dbg_addr),
        .dbg_data      (dbg_data)
    );

    function automatic logic [3:0] alu_ref(input logic [2:0] f, input logic [3:0] a,
                                           input logic [3:0] b);
        case (f)
            F_AND:   return a & b;
            F_OR:    return a | b;
            F_ADD:   return a + b;
            F_ANDN:  return a & ~b;
            F_ORN:   return a | ~b;
            F_SUB:   return a - b;
            F_SLT:   return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    always_comb begin
        alu_result = alu_ref(alu_funcsel, alu_operand_a, alu_operand_b);
        alu_zero   = (alu_result == 4'd0);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] rdm(input int i);
`ifdef RF_ZERO_REG_EN
        if (i == 0) return 4'd0;
`endif
        return mregs[i];
    endfunction

    // Called on the negedge before the accepting edge; updates the model and queues the write-back.
    task automatic push_op();
        exp_t       e;
        logic [3:0] a, b, r;
        a = rdm(int'(op_rs1));
        b = op_imm_en ? op_imm : rdm(int'(op_rs2));
        r = alu_ref(op_funcsel, a, b);
        mregs[op_rd] = r;
        e.rd       = op_rd;
        e.val      = rdm(int'(op_rd));
        e.zero     = (r == 4'd0);
        e.done_cyc = cyc + 2;
        sb.push_back(e);
    endtask

    task automatic drive(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic ie, input logic [3:0] imm);
        op_funcsel = f;
        op_rd      = rd;
        op_rs1     = rs1;
        op_rs2     = rs2;
        op_imm_en  = ie;
        op_imm     = imm;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        check("drain", sb.size(), 0);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic ie, input logic [3:0] imm);
        int k;
        @(negedge clk);
        drive(f, rd, rs1, rs2, ie, imm);
        op_valid = 1'b1;
        for (k = 0; k < 10 && !op_ready; k++) @(negedge clk);
        check("accept_ready", op_ready, 1);
        push_op();
        @(posedge clk);
        #1 op_valid = 1'b0;
        drain();
    endtask

    task automatic chk_reg(input string tag, input logic [2:0] idx, input logic [3:0] exp);
        @(negedge clk);
        main_addr = idx;
        #1 check(tag, dbg_data, exp);
    endtask

    // Write-back monitor: every done pulse must match the oldest queued op.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    e          = sb.pop_front();
                    mon_addr   = e.rd;
                    mon_active = 1'b1;
                    #1;
                    check("wb_data", dbg_data, e.val);
                    check("wb_zero", zero_flag, e.zero);
                    check("wb_latency", cyc, e.done_cyc);
                    mon_active = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [2:0] bp_f   [3];
        logic [2:0] bp_rd  [3];
        logic [2:0] bp_rs1 [3];
        logic [2:0] bp_rs2 [3];
        logic       bp_ie  [3];
        logic [3:0] bp_imm [3];
        int         acc_cyc [3];
        int         idx, dsnap;

        rst_n     = 1'b0;
        op_valid  = 1'b0;
        main_addr = '0;
        mon_addr  = '0;
        drive(3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 4'd0);
        for (int i = 0; i < 8; i++) mregs[i] = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset / idle state
        @(negedge clk);
        check("rst_ready", op_ready, 1);
        check("rst_done", done, 0);
        check("rst_zero_flag", zero_flag, 0);
        for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = 3'(i);
            chk_reg("rst_reg", a, 4'd0);
        end

        // Immediate forms and chained reads
        run_op(F_OR, 3'd1, 3'd0, 3'd0, 1'b1, 4'h5);
        run_op(F_ADD, 3'd2, 3'd1, 3'd0, 1'b1, 4'h3);
        chk_reg("r1_is_5", 3'd1, 4'h5);
        chk_reg("r2_is_8", 3'd2, 4'h8);

        // Zero results and wrap-around
        run_op(F_SUB, 3'd3, 3'd1, 3'd1, 1'b0, 4'h0);
        check("sub_zero_flag", zero_flag, 1);
        run_op(F_ADD, 3'd4, 3'd2, 3'd0, 1'b1, 4'h8);
        chk_reg("r4_wrap", 3'd4, 4'h0);
        check("wrap_zero_flag", zero_flag, 1);

        // Signed compare
        run_op(F_SLT, 3'd5, 3'd2, 3'd1, 1'b0, 4'h0);
        chk_reg("r5_slt", 3'd5, 4'h1);
        check("slt_zero_flag", zero_flag, 0);
        run_op(F_SLT, 3'd6, 3'd1, 3'd1, 1'b0, 4'h0);
        chk_reg("r6_slt", 3'd6, 4'h0);
        check("slt_eq_zero_flag", zero_flag, 1);

        // rd == rs1: old value read, new value written
        run_op(F_ADD, 3'd1, 3'd1, 3'd0, 1'b1, 4'h2);
        chk_reg("r1_self", 3'd1, 4'h7);

        // Backpressure: valid held for 9 cycles, three distinct ops
        bp_f   = '{F_ANDN, F_ORN, F_ADD};
        bp_rd  = '{3'd6, 3'd7, 3'd3};
        bp_rs1 = '{3'd1, 3'd0, 3'd1};
        bp_rs2 = '{3'd2, 3'd0, 3'd2};
        bp_ie  = '{1'b0, 1'b1, 1'b0};
        bp_imm = '{4'h0, 4'hE, 4'h0};
        idx = 0;
        for (int c = 0; c < 9; c++) begin
            int j;
            @(negedge clk);
            j = (idx > 2) ? 2 : idx;
            drive(bp_f[j], bp_rd[j], bp_rs1[j], bp_rs2[j], bp_ie[j], bp_imm[j]);
            op_valid = 1'b1;
            if (op_ready) begin
                if (idx < 3) acc_cyc[idx] = cyc;
                push_op();
                idx++;
            end
        end
        @(posedge clk);
        #1 op_valid = 1'b0;
        drain();
        check("bp_accepts", idx, 3);
        check("bp_gap1", acc_cyc[1] - acc_cyc[0], 3);
        check("bp_gap2", acc_cyc[2] - acc_cyc[1], 3);
        chk_reg("bp_r3", 3'd3, 4'hF);

        // Register 0 write: discarded only when hardwired
        run_op(F_OR, 3'd0, 3'd0, 3'd0, 1'b1, 4'hF);
`ifdef RF_ZERO_REG_EN
        chk_reg("r0_hardwired", 3'd0, 4'h0);
`else
        chk_reg("r0_written", 3'd0, 4'hF);
`endif

        // Reset in EXEC drops the op
        dsnap = done_cnt;
        @(negedge clk);
        drive(F_ADD, 3'd7, 3'd1, 3'd0, 1'b1, 4'h1);
        op_valid = 1'b1;
        check("rstx_ready", op_ready, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) mregs[i] = 4'd0;
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("rstx_no_done", done_cnt, dsnap);
        check("rstx_idle", op_ready, 1);
        check("rstx_zero_flag", zero_flag, 0);
        chk_reg("rstx_r7", 3'd7, 4'h0);
        chk_reg("rstx_r1", 3'd1, 4'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
